pc_ctrl: RTL and testbench
==========================

Name: pc_ctrl

Overview:
- Next-PC sequencer that drives the fetch-stage PC register's data input and write enable.
- Selects among reset vector, sequential PC+4, branch target, trap vector and MRET return address.
- Applies stall and flush policy, and holds fetch during a post-reset boot window.
- Sits between the hazard unit, the E-stage branch/exception logic and the PC register.

Parameters:
- RESET_VEC, 32'h0000_0000: first fetch address after boot; equals the RESET_LO constant.
- TRAP_VEC, 32'h0000_0010: trap handler entry address.
- BOOT_WAIT, 2: cycles held in BOOT before the first PC write (range 1..15).

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_clk_en  in  1  global clock enable; when 0, no state advances except pending-redirect capture.
- i_pc  in  32  current PC register value (feedback).
- i_stall_f  in  1  hazard-unit fetch stall.
- i_branch_taken  in  1  E-stage taken branch/jump.
- i_branch_target  in  32  branch/jump target.
- i_exception  in  1  E-stage exception request.
- i_exception_pc  in  32  PC of the faulting instruction.
- i_mret  in  1  E-stage MRET.
- i_mepc  in  32  saved return PC.
- o_pc_next  out  32  to PC register data input.
- o_pc_wr_en  out  1  to PC register write enable.
- o_flush_d  out  1  flush IF/ID.
- o_flush_e  out  1  flush ID/EX.
- o_mepc_we  out  1  capture o_mepc_wd into MEPC.
- o_mepc_wd  out  32  equals i_exception_pc.
- o_halted  out  1  high in the HALT state.
- o_misaligned  out  1  optional-feature flag.

Behaviour:
- States: BOOT, RUN, TRAP, HALT.
- Reset (async, i_rst_n=0):
  - state=BOOT, boot counter=0, pending redirect cleared.
  - All outputs 0, except o_pc_next=RESET_VEC.
- BOOT:
  - o_pc_wr_en=0; counter increments on each enabled cycle.
  - When counter==BOOT_WAIT-1: o_pc_wr_en=1 with o_pc_next=RESET_VEC for that cycle, then go to RUN.
- RUN, per enabled cycle, first match wins:
  1. i_exception: o_pc_next=TRAP_VEC, o_pc_wr_en=1, o_flush_d=o_flush_e=1, o_mepc_we=1; go to TRAP.
  2. i_mret: o_pc_next=i_mepc, o_pc_wr_en=1, both flushes=1.
  3. i_branch_taken: o_pc_next=i_branch_target, o_pc_wr_en=1, both flushes=1.
  4. i_stall_f: o_pc_wr_en=0, no flush.
  5. Otherwise: o_pc_next=i_pc+4 (mod 2^32; wraps from 32'hFFFF_FFFC to 0), o_pc_wr_en=1.
- Redirects (rules 1-3) override i_stall_f.
- Flushes and o_mepc_we are single-cycle pulses and are gated by i_clk_en.
- Pending redirect:
  - A rule-2 or rule-3 event while i_clk_en=0 is latched with its target. The latest event wins.
  - On the first enabled cycle, the pending redirect is applied as if newly asserted, unless i_exception is high (exception still wins). Pending is then cleared.
- TRAP (one enabled cycle, absorbs the pipeline refill):
  - o_pc_next=i_pc+4, write unless stalled.
  - If i_exception is asserted again: go to HALT (double fault). Otherwise go to RUN.
- HALT:
  - o_pc_wr_en=0, o_halted=1, no flushes.
  - Exit only through reset.
- Reset mid-operation aborts any state immediately; pending redirect is lost.
- o_pc_next is combinational from state and inputs; there is no added latency into the PC register.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - A redirect target (branch or mret) with bits[1:0]!=0 is treated as an exception instead: TRAP_VEC, flushes, MEPC written with i_exception_pc.
  - o_misaligned pulses for one cycle.
- Undefined: targets are used unchanged and o_misaligned is tied 0.

Decomposition:
- Shared constants header holds RESET_LO, the default TRAP_VEC and the state encodings (BOOT=0, RUN=1, TRAP=2, HALT=3).
- One natural sub-module, pc_redirect_buf: the pending-redirect latch (valid bit plus 32-bit target, last-write-wins, clear on apply).

Test Plan:
- Reset released, BOOT_WAIT=2, i_clk_en=1 -> o_pc_wr_en low for 1 cycle, then one write of 32'h0; RUN thereafter with 0x4, 0x8 sequential.
- i_pc=0x100 in RUN with i_branch_taken=1 and target 0x200, while i_stall_f=1 -> o_pc_next=0x200, o_pc_wr_en=1, both flushes for 1 cycle.
- i_exception with i_exception_pc=0x40 -> o_pc_next=0x10, o_mepc_we=1, o_mepc_wd=0x40; a second exception the next cycle -> o_halted=1 and no further writes until reset.
- i_clk_en=0 with i_mret=1, i_mepc=0x80 -> no write; first enabled cycle -> o_pc_next=0x80, flushes.
- i_pc=32'hFFFF_FFFC sequential -> o_pc_next=0.
- With PC_ALIGN_CHECK_EN defined, branch target 0x202 -> o_misaligned=1 and o_pc_next=0x10.

Source files
------------

// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg: shared constants, state encoding and alignment helper for the next-PC sequencer
package pc_ctrl_pkg;
  localparam logic [31:0] RESET_LO     = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC_DEF = 32'h0000_0010;
  localparam logic [31:0] PC_STEP      = 32'd4;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_TRAP = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction
endpackage

// File: rtl/pc_redirect_buf.sv
// pc_redirect_buf: holds an mret/branch redirect seen while the clock enable is low (last write wins)
module pc_redirect_buf
  import pc_ctrl_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_set,
  input  logic [31:0] i_set_target,
  input  logic        i_clr,
  output logic        o_valid,
  output logic [31:0] o_target
);
  // capture newest redirect; drop it once an enabled cycle has consumed it
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      o_valid  <= 1'b0;
      o_target <= '0;
    end else if (i_set) begin
      o_valid  <= 1'b1;
      o_target <= i_set_target;
    end else if (i_clr) begin
      o_valid  <= 1'b0;
    end
endmodule

// File: rtl/pc_ctrl.sv
// pc_ctrl: next-PC sequencer (boot hold, sequential, redirect, trap, halt); PC_ALIGN_CHECK_EN traps misaligned redirects
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = RESET_LO,
  parameter logic [31:0] TRAP_VEC  = TRAP_VEC_DEF,
  parameter int          BOOT_WAIT = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clk_en,
  input  logic [31:0] i_pc,
  input  logic        i_stall_f,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  input  logic        i_exception,
  input  logic [31:0] i_exception_pc,
  input  logic        i_mret,
  input  logic [31:0] i_mepc,
  output logic [31:0] o_pc_next,
  output logic        o_pc_wr_en,
  output logic        o_flush_d,
  output logic        o_flush_e,
  output logic        o_mepc_we,
  output logic [31:0] o_mepc_wd,
  output logic        o_halted,
  output logic        o_misaligned
);
  localparam logic [3:0] BOOT_LAST = 4'(BOOT_WAIT - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        en, live_rd, rd_req, rd_bad, pend_v;
  logic [31:0] live_tgt, rd_tgt, pend_tgt, pc_inc;

  // outputs are forced quiet while reset is held, even though the FSM is combinational
  assign en        = i_clk_en & i_rst_n;
  assign pc_inc    = i_pc + PC_STEP;
  assign live_rd   = i_mret | i_branch_taken;
  assign live_tgt  = i_mret ? i_mepc : i_branch_target;
  assign rd_req    = live_rd | pend_v;
  assign rd_tgt    = live_rd ? live_tgt : pend_tgt;
  assign o_mepc_wd = i_rst_n ? i_exception_pc : 32'd0;

`ifdef PC_ALIGN_CHECK_EN
  assign rd_bad = rd_req & is_misaligned(rd_tgt);
`else
  assign rd_bad = 1'b0;
`endif

  pc_redirect_buf u_buf (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_set        (state == ST_RUN && !i_clk_en && live_rd),
    .i_set_target (live_tgt),
    .i_clr        (en),
    .o_valid      (pend_v),
    .o_target     (pend_tgt)
  );

  // state and boot counter register
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state <= ST_BOOT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end

  // next-state and PC/flush selection; redirects beat stall, exceptions beat redirects
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    o_pc_next    = pc_inc;
    o_pc_wr_en   = 1'b0;
    o_flush_d    = 1'b0;
    o_flush_e    = 1'b0;
    o_mepc_we    = 1'b0;
    o_misaligned = 1'b0;
    o_halted     = state == ST_HALT;
    case (state)
      ST_BOOT: begin
        o_pc_next = RESET_VEC;
        if (en) begin
          o_pc_wr_en = cnt == BOOT_LAST;
          state_nxt  = cnt == BOOT_LAST ? ST_RUN : ST_BOOT;
          cnt_nxt    = cnt + 4'd1;
        end
      end
      ST_RUN: if (en) begin
        if (i_exception || rd_bad) begin
          o_pc_next    = TRAP_VEC;
          o_pc_wr_en   = 1'b1;
          o_flush_d    = 1'b1;
          o_flush_e    = 1'b1;
          o_mepc_we    = 1'b1;
          o_misaligned = !i_exception;
          state_nxt    = ST_TRAP;
        end else if (rd_req) begin
          o_pc_next  = rd_tgt;
          o_pc_wr_en = 1'b1;
          o_flush_d  = 1'b1;
          o_flush_e  = 1'b1;
        end else begin
          o_pc_wr_en = !i_stall_f;
        end
      end
      ST_TRAP: if (en) begin
        o_pc_wr_en = !i_stall_f;
        state_nxt  = i_exception ? ST_HALT : ST_RUN;
      end
      ST_HALT: o_pc_next = i_pc;
      default: state_nxt = ST_BOOT;
    endcase
  end
endmodule

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl: directed plus randomized checks of pc_ctrl against a cycle-level behavioural model
module tb_pc_ctrl;
  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0010;
  localparam int          BW = 2;

  logic i_clk = 0, i_rst_n = 0, i_clk_en = 0, i_stall_f = 0;
  logic i_branch_taken = 0, i_exception = 0, i_mret = 0;
  logic [31:0] i_pc = 0, i_branch_target = 0, i_exception_pc = 0, i_mepc = 0;
  logic [31:0] o_pc_next, o_mepc_wd;
  logic o_pc_wr_en, o_flush_d, o_flush_e, o_mepc_we, o_halted, o_misaligned;

  int errors = 0, checks = 0;
  int m_boot;
  bit m_trap, m_halt, m_pend;
  logic [31:0] m_paddr;

  always #5 i_clk = ~i_clk;

  pc_ctrl #(.RESET_VEC(RV), .TRAP_VEC(TV), .BOOT_WAIT(BW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clk_en(i_clk_en), .i_pc(i_pc),
    .i_stall_f(i_stall_f), .i_branch_taken(i_branch_taken), .i_branch_target(i_branch_target),
    .i_exception(i_exception), .i_exception_pc(i_exception_pc), .i_mret(i_mret), .i_mepc(i_mepc),
    .o_pc_next(o_pc_next), .o_pc_wr_en(o_pc_wr_en), .o_flush_d(o_flush_d), .o_flush_e(o_flush_e),
    .o_mepc_we(o_mepc_we), .o_mepc_wd(o_mepc_wd), .o_halted(o_halted), .o_misaligned(o_misaligned)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst_n = 0;
    i_exception_pc = $urandom;
    i_clk_en = 1;
    #1;
    check("rst_pc_next", o_pc_next, RV);
    check("rst_wr_en", o_pc_wr_en, 0);
    check("rst_flush", {o_flush_d, o_flush_e, o_mepc_we}, 0);
    check("rst_mepc_wd", o_mepc_wd, 0);
    check("rst_halted", o_halted, 0);
    check("rst_misaligned", o_misaligned, 0);
    m_boot = BW; m_trap = 0; m_halt = 0; m_pend = 0; m_paddr = 0;
  endtask

  task automatic cyc(input logic ce, input logic stall, input logic br, input logic [31:0] btgt,
                     input logic exc, input logic [31:0] epc, input logic mr, input logic [31:0] mepc,
                     input logic [31:0] pc);
    logic [31:0] e_next, tgt;
    logic e_wr, e_fl, e_mwe, e_mis, have, bad, chk_pc;
    @(negedge i_clk);
    i_rst_n = 1; i_clk_en = ce; i_stall_f = stall; i_branch_taken = br; i_branch_target = btgt;
    i_exception = exc; i_exception_pc = epc; i_mret = mr; i_mepc = mepc; i_pc = pc;
    #1;
    e_next = pc + 32'd4; e_wr = 0; e_fl = 0; e_mwe = 0; e_mis = 0; chk_pc = 0;
    have = mr | br | m_pend;
    tgt = mr ? mepc : br ? btgt : m_paddr;
    bad = 0;
`ifdef PC_ALIGN_CHECK_EN
    bad = have && tgt[1:0] != 2'b00;
`endif
    check("halted", o_halted, m_halt);
    if (m_boot > 0) begin
      e_next = RV; chk_pc = 1;
      if (ce) begin e_wr = m_boot == 1; m_boot--; end
    end else if (m_halt) begin
    end else if (m_trap) begin
      if (ce) begin e_wr = !stall; m_halt = exc; m_trap = 0; end
    end else if (!ce) begin
      if (mr | br) begin m_pend = 1; m_paddr = mr ? mepc : btgt; end
    end else if (exc || bad) begin
      e_next = TV; e_wr = 1; e_fl = 1; e_mwe = 1; e_mis = !exc; m_trap = 1;
    end else if (have) begin
      e_next = tgt; e_wr = 1; e_fl = 1;
    end else begin
      e_wr = !stall;
    end
    if (ce) m_pend = 0;
    if (e_wr || chk_pc) check("pc_next", o_pc_next, e_next);
    check("pc_wr_en", o_pc_wr_en, e_wr);
    check("flush_d", o_flush_d, e_fl);
    check("flush_e", o_flush_e, e_fl);
    check("mepc_we", o_mepc_we, e_mwe);
    check("mepc_wd", o_mepc_wd, epc);
    check("misaligned", o_misaligned, e_mis);
  endtask

  function automatic logic [31:0] rtgt();
    logic [31:0] t;
    t = $urandom & 32'hFFFF_FFFC;
    if ($urandom_range(0, 5) == 0) t[1:0] = 2'($urandom_range(1, 3));
    return t;
  endfunction

  initial begin
    logic [31:0] pc;
    do_reset();
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("tp_boot_hold", o_pc_wr_en, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("tp_boot_wr", {o_pc_wr_en, o_pc_next}, {1'b1, 32'h0});
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    check("tp_seq4", o_pc_next, 32'h4);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 32'h4);
    check("tp_seq8", o_pc_next, 32'h8);
    cyc(1, 1, 1, 32'h200, 0, 0, 0, 0, 32'h100);
    check("tp_branch", {o_pc_wr_en, o_flush_d, o_flush_e, o_pc_next}, {3'b111, 32'h200});
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 32'h200);
    check("tp_flush_pulse", {o_flush_d, o_flush_e}, 0);
    cyc(1, 0, 0, 0, 1, 32'h40, 0, 0, 32'h204);
    check("tp_exc", {o_mepc_we, o_pc_next, o_mepc_wd}, {1'b1, 32'h10, 32'h40});
    cyc(1, 0, 0, 0, 1, 32'h44, 0, 0, 32'h10);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 32'h14);
    check("tp_halted", {o_halted, o_pc_wr_en}, 2'b10);
    cyc(1, 0, 1, 32'h300, 0, 0, 0, 0, 32'h14);
    check("tp_halt_nowr", o_pc_wr_en, 0);
    do_reset();
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 32'h80, 32'h4);
    check("tp_mret_gated", o_pc_wr_en, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 32'h4);
    check("tp_mret_pend", {o_pc_wr_en, o_flush_d, o_flush_e, o_pc_next}, {3'b111, 32'h80});
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFC);
    check("tp_wrap", o_pc_next, 32'h0);
`ifdef PC_ALIGN_CHECK_EN
    cyc(1, 0, 1, 32'h202, 0, 32'h50, 0, 0, 32'h100);
    check("tp_misaligned", {o_misaligned, o_pc_next}, {1'b1, 32'h10});
`endif
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      pc = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      cyc($urandom_range(0, 99) < 85, $urandom_range(0, 3) == 0, $urandom_range(0, 99) < 15, rtgt(),
          $urandom_range(0, 99) < 4, $urandom, $urandom_range(0, 99) < 8, rtgt(), pc);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
